exotiny_console: RTL and testbench

Console sink for ExoTiny firmware output, replacing the simulation-only GPIO character sniffer with synthesizable hardware.
- Wishbone slave on the data-memory bus; accepts byte writes into a TX FIFO and serializes them on an 8N1 UART line.
- Tracks the last four accepted bytes and raises sticky done/err flags on the "DONE"/"ERR" test signatures, so silicon and simulation end tests identically.

---
 rtl/exotiny_console_pkg.sv | 27 ++
 rtl/exotiny_console_uart_tx.sv | 113 +++++++++++
 rtl/exotiny_console.sv | 132 +++++++++++++
 tb/tb_exotiny_console.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exotiny_console_pkg.sv
// Shared definitions for the ExoTiny console sink.
//   - UART transmitter state encoding
//   - Wishbone word addresses (TXDATA / STATUS)
//   - STATUS register bit positions
//   - Firmware end-of-test signatures ("DONE", "ERR")
package exotiny_console_pkg;

   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_e;

   localparam logic ADR_TXDATA = 1'b0;
   localparam logic ADR_STATUS = 1'b1;

   localparam int ST_BUSY  = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_DONE  = 3;
   localparam int ST_ERR   = 4;

   localparam logic [31:0] SIG_DONE = 32'h444F_4E45;  // "DONE"
   localparam logic [23:0] SIG_ERR  = 24'h45_5252;    // "ERR"

endpackage

// File: rtl/exotiny_console_uart_tx.sv
// 8N1 UART transmitter, one byte per handshake.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        byte available at data_i
//   data_i[7:0]    byte to send
//   ready_o        byte is taken on valid_i & ready_o
//   busy_o         a frame is in progress (state != IDLE)
//   tx_o           serial line, idle high
module exotiny_console_uart_tx
   import exotiny_console_pkg::*;
#(
   parameter int CLKDIV = 87
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       tx_o
);

   localparam int            CW       = $clog2(CLKDIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

   uart_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shr_q, shr_d;
   logic          tx_q, tx_d;
   logic          period_end;

   assign period_end = (cnt_q == CNT_LAST);

   // Also ready in the last STOP cycle so a queued byte goes straight
   // into START: the stop bit is exactly CLKDIV long and frames abut.
   assign ready_o = (state_q == UART_IDLE) ||
                    ((state_q == UART_STOP) && period_end);
   assign busy_o  = (state_q != UART_IDLE);
   assign tx_o    = tx_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= UART_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shr_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shr_q   <= shr_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shr_d   = shr_q;
      tx_d    = 1'b1;

      // Bit-period counter runs in every non-idle state and wraps at CLKDIV.
      if (state_q != UART_IDLE)
         cnt_d = period_end ? '0 : cnt_q + 1'b1;

      case (state_q)
         UART_IDLE: begin
            if (valid_i) begin
               state_d = UART_START;
               shr_d   = data_i;
               cnt_d   = '0;
            end
         end
         UART_START: begin
            if (period_end) begin
               state_d = UART_DATA;
               bit_d   = '0;
            end
         end
         UART_DATA: begin
            if (period_end) begin
               shr_d = {1'b0, shr_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7)
                  state_d = UART_STOP;
            end
         end
         UART_STOP: begin
            if (period_end) begin
               if (valid_i) begin
                  state_d = UART_START;
                  shr_d   = data_i;
               end else begin
                  state_d = UART_IDLE;
               end
            end
         end
         default: state_d = UART_IDLE;
      endcase

      // Line level is registered from the next state so tx_o is glitch-free
      // and lines up cycle-for-cycle with state_q.
      case (state_d)
         UART_START: tx_d = 1'b0;
         UART_DATA:  tx_d = shr_d[0];
         default:    tx_d = 1'b1;
      endcase
   end

endmodule

// File: rtl/exotiny_console.sv
// ExoTiny console sink: Wishbone slave feeding a TX FIFO and an 8N1 UART,
// plus sticky detectors for the firmware "DONE"/"ERR" end-of-test strings.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   wb_stb_i         strobe, held by the master until ack
//   wb_we_i          write enable
//   wb_adr_i         0 = TXDATA, 1 = STATUS
//   wb_dat_i[7:0]    write data (low byte of the CPU word)
//   wb_dat_o[31:0]   registered read data, valid with ack
//   wb_ack_o         single-cycle acknowledge
//   tx_o             UART line, idle high
//   done_o, err_o    sticky signature flags
module exotiny_console
   import exotiny_console_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int CLKDIV = 87
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic        wb_adr_i,
   input  logic [7:0]  wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        tx_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int AW = $clog2(DEPTH);

   // ---------------- TX FIFO ----------------
   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic        fifo_full, fifo_empty;
   logic        push, pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) mem[wptr_q[AW-1:0]] <= wb_dat_i;
   end

   // ---------------- UART ----------------
   logic uart_ready, uart_busy;

   // A pop only ever reads an existing entry (never the byte being pushed),
   // and a push is never accepted while full, so occupancy stays exact.
   assign pop = !fifo_empty && uart_ready;

   exotiny_console_uart_tx #(
      .CLKDIV (CLKDIV)
   ) u_uart_tx (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (!fifo_empty),
      .data_i  (mem[rptr_q[AW-1:0]]),
      .ready_o (uart_ready),
      .busy_o  (uart_busy),
      .tx_o    (tx_o)
   );

   // ---------------- Wishbone ----------------
   logic        pending, tx_wr, ack_d, status_rd;
   logic [31:0] status, rdata_d;

   // Gating with ack keeps a held strobe from being served twice, which
   // also guarantees ack never fires in consecutive cycles.
   assign pending   = wb_stb_i && !wb_ack_o;
   assign tx_wr     = pending && wb_we_i && (wb_adr_i == ADR_TXDATA);
   assign push      = tx_wr && !fifo_full;
   assign ack_d     = pending && !(tx_wr && fifo_full);
   assign status_rd = pending && !wb_we_i && (wb_adr_i == ADR_STATUS);

   logic        done_q, err_q;
   logic [31:0] sig_q;

   always_comb begin
      status           = '0;
      status[ST_BUSY]  = uart_busy;
      status[ST_FULL]  = fifo_full;
      status[ST_EMPTY] = fifo_empty;
      status[ST_DONE]  = done_q;
      status[ST_ERR]   = err_q;
      rdata_d          = status_rd ? status : 32'd0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= ack_d;
         wb_dat_o <= rdata_d;
      end
   end

   // ---------------- Signature detector ----------------
   // Flags compare the registered history, so they rise one cycle after the
   // ack of the byte that completes the signature.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (push) sig_q <= {sig_q[23:0], wb_dat_i};
         if (sig_q == SIG_DONE)      done_q <= 1'b1;
         if (sig_q[23:0] == SIG_ERR) err_q  <= 1'b1;
      end
   end

   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_exotiny_console.sv
// Directed bench for exotiny_console (DEPTH=4, CLKDIV=4). A line/flag model
// built from the accepted byte stream is compared against the DUT on every
// cycle; hand-computed literals pin the model and the bus timing.
module tb_exotiny_console;

   localparam int DEPTH = 4;
   localparam int CD    = 4;
   localparam int FRAME = 10 * CD;
   localparam int NCYC  = 8192;
   localparam int INF   = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic        adr = 1'b0;
   logic [7:0]  dat = 8'h00;
   logic [31:0] dat_o;
   logic        ack, tx, done, err;

   exotiny_console #(.DEPTH(DEPTH), .CLKDIV(CD)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_dat_i (dat),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack),
      .tx_o     (tx),
      .done_o   (done),
      .err_o    (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   bit         exp_line [NCYC];
   int         free_at = 0;
   int         done_at = INF;
   int         err_at  = INF;
   logic [7:0] hist [$];
   bit         chk_en  = 0;
   logic       ack_prev = 1'b0;

   // A byte accepted at cycle c starts its frame the next cycle, or right
   // after the previous frame if the line is still busy.
   task automatic model_push(input logic [7:0] b, input int c);
      int start;
      int n;
      logic [9:0] fr;
      start = (c + 1 > free_at) ? c + 1 : free_at;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < FRAME; i++)
         if (start + i < NCYC) exp_line[start + i] = fr[i / CD];
      free_at = start + FRAME;
      hist.push_back(b);
      n = hist.size();
      if (n >= 4 && done_at == INF &&
          {hist[n-4], hist[n-3], hist[n-2], hist[n-1]} == "DONE")
         done_at = c + 1;
      if (n >= 3 && err_at == INF && {hist[n-3], hist[n-2], hist[n-1]} == "ERR")
         err_at = c + 1;
   endtask

   task automatic model_reset(input int from);
      for (int k = from; k < NCYC; k++) exp_line[k] = 1'b1;
      free_at = 0;
      done_at = INF;
      err_at  = INF;
      hist.delete();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (cyc < NCYC) check("tx_line", tx, exp_line[cyc]);
         check("done_flag", done, cyc >= done_at);
         check("err_flag", err, cyc >= err_at);
         check("ack_single_cycle", ack & ack_prev, 0);
         ack_prev = ack;
      end
   end

   // ---------------- bus driver ----------------
   // Called at a negedge; returns at the negedge where ack is seen.
   task automatic wb_xfer(input logic w, input logic a, input logic [7:0] d,
                          output logic [31:0] rd, output int ack_cyc, output int lat);
      stb = 1'b1; we = w; adr = a; dat = d;
      lat = 0; ack_cyc = -1;
      while (ack_cyc < 0 && lat < 400) begin
         @(negedge clk);
         lat++;
         if (ack) ack_cyc = cyc;
      end
      rd = dat_o;
      stb = 1'b0; we = 1'b0;
      if (ack_cyc < 0) begin
         checks++; errors++;
         $display("FAIL bus_ack_timeout: no ack after %0d cycles (required ack)", lat);
      end else if (w && a == 1'b0) begin
         model_push(d, ack_cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_line();
      int guard = 0;
      while (cyc < free_at + 2 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset(cyc);
      #1;
      check("rst_async_tx", tx, 1);
      check("rst_async_done", done, 0);
      check("rst_async_err", err, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   logic [31:0] rd;
   int          ac, lat, c0;
   int          acks [6];
   logic [9:0]  f_bits, l_bits;
   logic [7:0]  s_done [5];
   logic [7:0]  s_err [3];

   initial begin
      #200000;
      $display("FAIL sim_timeout: run did not finish (required finish)");
      $fatal(1, "timeout");
   end

   initial begin
      s_done = '{8'h78, 8'h44, 8'h4F, 8'h4E, 8'h45};  // "xDONE"
      s_err  = '{8'h45, 8'h52, 8'h52};                // "ERR"
      model_reset(0);

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_ack", ack, 0);
      check("reset_dat_o", dat_o, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      rst = 1'b0;
      chk_en = 1;
      idle(1);

      // ---- idle STATUS read, TXDATA read, ignored STATUS write ----
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_idle", rd, 32'h4);
      check("read_latency", lat, 1);
      idle(1);
      wb_xfer(0, 0, 8'h00, rd, ac, lat);
      check("txdata_read_zero", rd, 0);
      idle(1);
      wb_xfer(1, 1, 8'hFF, rd, ac, lat);
      check("status_write_latency", lat, 1);
      idle(1);
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_after_wr", rd, 32'h4);
      idle(2);

      // ---- single byte 0x41 ----
      wb_xfer(1, 0, 8'h41, rd, c0, lat);
      check("write_latency", lat, 1);
      fork
         begin
            for (int k = 1; k <= FRAME; k++) begin
               @(negedge clk);
               if ((k - 1) % CD == 0) f_bits[(k - 1) / CD] = tx;
               if (k % CD == 0)       l_bits[k / CD - 1]   = tx;
            end
         end
         begin
            logic [31:0] r;
            int a2, l2;
            idle(3);
            wb_xfer(0, 1, 8'h00, r, a2, l2);
            check("status_busy", r, 32'h5);
         end
      join
      check("frame41_bit_start", f_bits, 10'h282);
      check("frame41_bit_end", l_bits, 10'h282);
      idle(2);
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_after_frame", rd, 32'h4);
      idle(2);

      // ---- back-to-back writes into a 4-deep FIFO ----
      for (int i = 0; i < 5; i++) begin
         wb_xfer(1, 0, 8'hA0 + 8'(i), rd, acks[i], lat);
         if (i > 0) check("b2b_ack_spacing", acks[i] - acks[i-1], 2);
      end
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_full", rd, 32'h3);
      wb_xfer(1, 0, 8'hA5, rd, acks[5], lat);
      // first frame runs acks[0]+1 .. acks[0]+40; second byte pops at
      // edge acks[0]+41, the stalled write is acked on the next edge
      check("stalled_ack_cycle", acks[5] - acks[0], 42);
      wait_line();
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_drained", rd, 32'h4);

      // ---- "xDONE" ----
      for (int i = 0; i < 5; i++) wb_xfer(1, 0, s_done[i], rd, ac, lat);
      check("done_at_ack", done, 0);
      @(negedge clk);
      check("done_rise", done, 1);
      check("done_no_err", err, 0);
      do_reset();
      check("done_cleared", done, 0);
      idle(2);

      // ---- "ERR" then "DONE" ----
      for (int i = 0; i < 3; i++) wb_xfer(1, 0, s_err[i], rd, ac, lat);
      @(negedge clk);
      check("err_rise", err, 1);
      wait_line();
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_err", rd, 32'h14);
      for (int i = 1; i < 5; i++) wb_xfer(1, 0, s_done[i], rd, ac, lat);
      wait_line();
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("status_err_done", rd, 32'h1C);
      check("both_flags", {done, err}, 2'b11);
      idle(2);

      // ---- reset in the middle of a data bit ----
      wb_xfer(1, 0, 8'h00, rd, c0, lat);
      wb_xfer(1, 0, 8'hAA, rd, ac, lat);
      while (cyc < c0 + 10) @(negedge clk);
      check("mid_data_low", tx, 0);
      do_reset();
      check("post_rst_flags", {done, err}, 2'b00);
      idle(1);
      wb_xfer(0, 1, 8'h00, rd, ac, lat);
      check("post_rst_status", rd, 32'h4);
      idle(60);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
